// File: rtl/telemeter_system_nios2_qsys_cpu_div_cell.sv
// rtl/telemeter_system_nios2_qsys_cpu_div_cell.sv - iterative 32-bit restoring divider (div/divu)
// Optional macro TELEMETER_DIV_FAST_ZERO_EN: zero divisor bypasses the iterations.
module telemeter_system_nios2_qsys_cpu_div_cell (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] E_src1,
  input  logic [31:0] E_src2,
  input  logic        E_div_signed,
  input  logic        E_div_start,
  input  logic        A_div_kill,
  output logic        M_div_busy,
  output logic        M_div_done,
  output logic [31:0] M_div_quot,
  output logic [31:0] M_div_rem
);

  typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIX} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [31:0] rem_r, dvd_r, dvs_r, orig_dvd;
  logic        q_neg, r_neg, div_zero;

  logic        start_ok, sign1, sign2, zero_skip, ge;
  logic [31:0] mag1, mag2, fix_q, fix_r;
  logic [32:0] trial, diff;

  assign start_ok = (state == S_IDLE) && E_div_start && !A_div_kill;
  assign sign1    = E_div_signed & E_src1[31];
  assign sign2    = E_div_signed & E_src2[31];
  assign mag1     = sign1 ? -E_src1 : E_src1;
  assign mag2     = sign2 ? -E_src2 : E_src2;

`ifdef TELEMETER_DIV_FAST_ZERO_EN
  assign zero_skip = (E_src2 == 32'd0);
`else
  assign zero_skip = 1'b0;
`endif

  // rem < divisor keeps trial below 2^33; trial[32] set means the subtract cannot go negative
  assign trial = {rem_r, dvd_r[31]};
  assign diff  = trial - {1'b0, dvs_r};
  assign ge    = trial[32] | ~diff[32];

  assign fix_q = div_zero ? 32'hFFFF_FFFF : (q_neg ? -dvd_r : dvd_r);
  assign fix_r = div_zero ? orig_dvd      : (r_neg ? -rem_r : rem_r);

  always_ff @(posedge clk) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (start_ok) state_nxt = zero_skip ? S_FIX : S_ITER;
      S_ITER: begin
        if (A_div_kill)       state_nxt = S_IDLE;
        else if (cnt == 6'd31) state_nxt = S_FIX;
      end
      S_FIX:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    M_div_busy = (state != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt        <= 6'd0;
      rem_r      <= 32'd0;
      dvd_r      <= 32'd0;
      dvs_r      <= 32'd0;
      orig_dvd   <= 32'd0;
      q_neg      <= 1'b0;
      r_neg      <= 1'b0;
      div_zero   <= 1'b0;
      M_div_quot <= 32'd0;
      M_div_rem  <= 32'd0;
      M_div_done <= 1'b0;
    end else begin
      M_div_done <= 1'b0;
      case (state)
        S_IDLE: if (start_ok) begin
          dvd_r    <= mag1;
          dvs_r    <= mag2;
          rem_r    <= 32'd0;
          cnt      <= 6'd0;
          q_neg    <= sign1 ^ sign2;
          r_neg    <= sign1;
          div_zero <= (E_src2 == 32'd0);
          orig_dvd <= E_src1;
        end
        S_ITER: if (!A_div_kill) begin
          rem_r <= ge ? diff[31:0] : trial[31:0];
          dvd_r <= {dvd_r[30:0], ge};
          cnt   <= cnt + 6'd1;
        end
        S_FIX: if (!A_div_kill) begin
          M_div_quot <= fix_q;
          M_div_rem  <= fix_r;
          M_div_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_telemeter_system_nios2_qsys_cpu_div_cell.sv
// tb/tb_telemeter_system_nios2_qsys_cpu_div_cell.sv - directed and random checks of the divider
module tb_telemeter_system_nios2_qsys_cpu_div_cell;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] src1, src2;
  logic        div_signed, div_start, div_kill;
  logic        busy, done;
  logic [31:0] quot, rem;

  int total = 0;
  int bad   = 0;

`ifdef TELEMETER_DIV_FAST_ZERO_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 33;
`endif

  telemeter_system_nios2_qsys_cpu_div_cell dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .E_src1       (src1),
    .E_src2       (src2),
    .E_div_signed (div_signed),
    .E_div_start  (div_start),
    .A_div_kill   (div_kill),
    .M_div_busy   (busy),
    .M_div_done   (done),
    .M_div_quot   (quot),
    .M_div_rem    (rem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int lat, output int bcnt);
    lat  = 0;
    bcnt = 0;
    while (!done && lat < 60) begin
      if (busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic watch_no_done(input string tag);
    int n = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) n++;
    end
    check(tag, n, 0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                        input logic [31:0] eq, input logic [31:0] er, input int elat,
                        input string tag);
    int lat, bc;
    @(negedge clk);
    src1 = a; src2 = b; div_signed = s; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    wait_done(lat, bc);
    check({tag, " lat"}, lat, elat);
    check({tag, " busy"}, bc, elat);
    check({tag, " quot"}, quot, eq);
    check({tag, " rem"}, rem, er);
    @(posedge clk); #1;
    check({tag, " done pulse"}, done, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    int k, lat, bc;
    logic [31:0] a, b, eq, er;
    logic signed [31:0] sa, sb;
    logic s;

    reset_n = 1'b0; src1 = '0; src2 = '0; div_signed = 1'b0; div_start = 1'b0; div_kill = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst quot", quot, 32'd0);
    check("rst rem", rem, 32'd0);
    reset_n = 1'b1;

    run_op(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33, "u100/7");
    run_op(32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33, "s-100/7");
    run_op(32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 33, "s100/-7");
    run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0, 33, "s ovf");
    run_op(32'hFFFF_FFFF, 32'd16, 1'b0, 32'h0FFF_FFFF, 32'd15, 33, "u max/16");
    run_op(32'h1234_5678, 32'd0, 1'b1, 32'hFFFF_FFFF, 32'h1234_5678, ZERO_LAT, "s /0");
    run_op(32'h8765_4321, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'h8765_4321, ZERO_LAT, "u /0");

    // starts at N+5 and N+20 fall while busy and must be dropped
    @(negedge clk);
    src1 = 32'd1000; src2 = 32'd3; div_signed = 1'b0; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    k = 0;
    while (!done && k < 60) begin
      @(negedge clk);
      if (k == 4 || k == 19) begin
        src1 = 32'd5; src2 = 32'd1; div_start = 1'b1;
      end
      @(posedge clk); #1;
      div_start = 1'b0;
      k++;
    end
    check("ignore lat", k, 33);
    check("ignore quot", quot, 32'd333);
    check("ignore rem", rem, 32'd1);

    // start raised inside the done cycle
    src1 = 32'd77; src2 = 32'd5; div_signed = 1'b0; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    wait_done(lat, bc);
    check("b2b lat", lat, 33);
    check("b2b quot", quot, 32'd15);
    check("b2b rem", rem, 32'd2);

    // kill at N+10
    @(negedge clk);
    src1 = 32'd50; src2 = 32'd5; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    div_kill = 1'b1;
    @(posedge clk); #1;
    div_kill = 1'b0;
    check("kill busy", busy, 1'b0);
    watch_no_done("kill no done");
    check("kill quot", quot, 32'd15);
    check("kill rem", rem, 32'd2);

    // reset at N+15
    @(negedge clk);
    src1 = 32'd9; src2 = 32'd2; div_start = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0;
    repeat (14) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("midrst busy", busy, 1'b0);
    check("midrst done", done, 1'b0);
    check("midrst quot", quot, 32'd0);
    check("midrst rem", rem, 32'd0);
    reset_n = 1'b1;
    watch_no_done("midrst no done");

    // kill and start together in IDLE
    @(negedge clk);
    src1 = 32'd20; src2 = 32'd4; div_start = 1'b1; div_kill = 1'b1;
    @(posedge clk); #1;
    div_start = 1'b0; div_kill = 1'b0;
    check("killstart busy", busy, 1'b0);
    watch_no_done("killstart no done");
    check("killstart quot", quot, 32'd0);

    for (int i = 0; i < 150; i++) begin
      a = $urandom;
      b = $urandom;
      if (i % 3 == 0) b = b >> $urandom_range(31, 8);
      if (b == 32'd0) b = 32'd1;
      s = i[0];
      if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) b = 32'd3;
      if (s) begin
        sa = a; sb = b;
        eq = sa / sb;
        er = sa % sb;
      end else begin
        eq = a / b;
        er = a % b;
      end
      run_op(a, b, s, eq, er, 33, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
